// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with relative branch and hardware call/return stack
// Stack misuse (CALL when full, RET when empty) is refused and flagged for one cycle.
module pc_stack #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               STEP        = 1,
  parameter int               STACK_DEPTH = 8
) (
  input  logic                               I_clk,
  input  logic                               I_reset,
  input  logic                               I_enable,
  input  logic [2:0]                         I_op,
  input  logic [WIDTH-1:0]                   I_in,
  output logic [WIDTH-1:0]                   O_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   O_depth,
  output logic                               O_full,
  output logic                               O_empty,
  output logic                               O_overflow,
  output logic                               O_underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JMP    = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [WIDTH-1:0] r_pc;
  logic [DW-1:0]    r_depth;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic [WIDTH-1:0] w_next_seq;

  always_comb begin
    w_full     = (r_depth == FULL_DEPTH);
    w_empty    = (r_depth == '0);
    w_push     = I_enable && (I_op == OP_CALL) && !w_full;
    w_pop      = I_enable && (I_op == OP_RET) && !w_empty;
    w_wr_idx   = r_depth[IW-1:0];
    w_rd_idx   = IW'(r_depth - DW'(1));
    w_next_seq = r_pc + WIDTH'(STEP);
  end

  // Stack contents need no reset: entries above r_depth are never read.
  always_ff @(posedge I_clk) begin
    if (w_push) r_stack[w_wr_idx] <= w_next_seq;
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_pc        <= RESET_VEC;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= I_enable && (I_op == OP_CALL) && w_full;
      r_underflow <= I_enable && (I_op == OP_RET) && w_empty;
      if (I_enable) begin
        case (I_op)
          OP_INC:    r_pc <= w_next_seq;
          OP_JMP:    r_pc <= I_in;
          OP_BRANCH: r_pc <= r_pc + I_in;
          OP_CALL: begin
            if (w_push) begin
              r_pc    <= I_in;
              r_depth <= r_depth + DW'(1);
            end
          end
          OP_RET: begin
            if (w_pop) begin
              r_pc    <= r_stack[w_rd_idx];
              r_depth <= r_depth - DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign O_out       = r_pc;
  assign O_depth     = r_depth;
  assign O_full      = w_full;
  assign O_empty     = w_empty;
  assign O_overflow  = r_overflow;
  assign O_underflow = r_underflow;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - randomized self-checking bench for pc_stack against a queue-based model
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [15:0] din = '0;
  logic [15:0] o_out;
  logic [3:0]  o_depth;
  logic        o_full, o_empty, o_ovf, o_unf;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf, m_unf;

  localparam logic [15:0] RV = 16'h0100;

  pc_stack #(.WIDTH(16), .RESET_VEC(16'h0100), .STEP(1), .STACK_DEPTH(8)) dut (
    .I_clk(clk), .I_reset(rst), .I_enable(en), .I_op(op), .I_in(din),
    .O_out(o_out), .O_depth(o_depth), .O_full(o_full), .O_empty(o_empty),
    .O_overflow(o_ovf), .O_underflow(o_unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one op at the falling edge, let the rising edge take it, update the model.
  task automatic step(input logic e, input logic [2:0] o, input logic [15:0] d);
    @(negedge clk);
    en = e; op = o; din = d;
    @(posedge clk);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (e) begin
      case (o)
        3'd0: m_pc = m_pc + 16'd1;
        3'd1: m_pc = d;
        3'd2: m_pc = m_pc + d;
        3'd3: if (m_stack.size() < 8) begin m_stack.push_back(m_pc + 16'd1); m_pc = d; end
              else m_ovf = 1'b1;
        3'd4: if (m_stack.size() > 0) m_pc = m_stack.pop_back();
              else m_unf = 1'b1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'h0101; exp_pc[1] = 16'h0102; exp_pc[2] = 16'h0103;
    do_reset();
    checks++;
    if (o_out !== 16'h0100 || o_depth !== 4'd0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
        o_ovf !== 1'b0 || o_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want 0100 0 1 0 0 0",
               o_out, o_depth, o_empty, o_full, o_ovf, o_unf);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, 16'($urandom));
      checks++;
      if (o_out !== exp_pc[i] || o_empty !== 1'b1) begin
        errors++;
        $display("FAIL inc_%0d: out=%h empty=%b, want %h 1", i, o_out, o_empty, exp_pc[i]);
      end
    end
  endtask

  task automatic test_wrap_branch();
    step(1'b1, 3'd1, 16'hFFFF);
    step(1'b1, 3'd0, 16'h1234);
    checks++;
    if (o_out !== 16'h0000) begin
      errors++; $display("FAIL inc_wrap: out=%h, want 0000", o_out);
    end
    step(1'b1, 3'd1, 16'h0010);
    step(1'b1, 3'd2, 16'hFFFE);
    checks++;
    if (o_out !== 16'h000E) begin
      errors++; $display("FAIL branch_neg: out=%h, want 000e", o_out);
    end
    step(1'b1, 3'd2, 16'h7000);
    checks++;
    if (o_out !== m_pc) begin
      errors++; $display("FAIL branch_pos: out=%h, want %h", o_out, m_pc);
    end
  endtask

  task automatic test_call_ret();
    step(1'b1, 3'd1, 16'h0020);
    step(1'b1, 3'd3, 16'h0400);
    checks++;
    if (o_out !== 16'h0400 || o_depth !== 4'd1 || o_empty !== 1'b0) begin
      errors++; $display("FAIL call: out=%h depth=%0d empty=%b, want 0400 1 0", o_out, o_depth, o_empty);
    end
    step(1'b1, 3'd4, 16'h0);
    checks++;
    if (o_out !== 16'h0021 || o_depth !== 4'd0 || o_empty !== 1'b1) begin
      errors++; $display("FAIL ret: out=%h depth=%0d empty=%b, want 0021 0 1", o_out, o_depth, o_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] held;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd3, 16'($urandom));
      checks++;
      if (o_out !== m_pc || o_depth !== 4'(i + 1) || o_full !== (i == 7)) begin
        errors++;
        $display("FAIL nest_call_%0d: out=%h depth=%0d full=%b, want %h %0d %b",
                 i, o_out, o_depth, o_full, m_pc, i + 1, (i == 7));
      end
    end
    held = m_pc;
    step(1'b1, 3'd3, 16'hBEEF);
    checks++;
    if (o_ovf !== 1'b1 || o_out !== held || o_depth !== 4'd8 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ovf=%b out=%h depth=%0d, want 1 %h 8", o_ovf, o_out, o_depth, held);
    end
    step(1'b1, 3'd6, 16'h0);
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++; $display("FAIL overflow_pulse: ovf=%b, want 0", o_ovf);
    end
    step(1'b1, 3'd3, 16'h1111);
    step(1'b1, 3'd3, 16'h2222);
    checks++;
    if (o_ovf !== 1'b1 || o_out !== held) begin
      errors++; $display("FAIL overflow_b2b: ovf=%b out=%h, want 1 %h", o_ovf, o_out, held);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd4, 16'($urandom));
      checks++;
      if (o_out !== m_pc || o_depth !== 4'(7 - i) || o_ovf !== 1'b0) begin
        errors++;
        $display("FAIL unwind_%0d: out=%h depth=%0d, want %h %0d", i, o_out, o_depth, m_pc, 7 - i);
      end
    end
  endtask

  task automatic test_underflow_enable();
    logic [15:0] held;
    held = m_pc;
    step(1'b1, 3'd4, 16'h0);
    checks++;
    if (o_unf !== 1'b1 || o_out !== held || o_depth !== 4'd0) begin
      errors++; $display("FAIL underflow: unf=%b out=%h depth=%0d, want 1 %h 0", o_unf, o_out, o_depth, held);
    end
    step(1'b1, 3'd3, 16'h0300);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'(i), 16'($urandom));
      checks++;
      if (o_out !== 16'h0300 || o_depth !== 4'd1 || o_unf !== 1'b0 || o_ovf !== 1'b0) begin
        errors++;
        $display("FAIL disabled_op%0d: out=%h depth=%0d unf=%b ovf=%b, want 0300 1 0 0",
                 i, o_out, o_depth, o_unf, o_ovf);
      end
    end
    step(1'b1, 3'd4, 16'h0);
    step(1'b1, 3'd4, 16'h0);
    step(1'b0, 3'd4, 16'h0);
    checks++;
    if (o_unf !== 1'b0 || o_out !== m_pc) begin
      errors++; $display("FAIL underflow_clear: unf=%b out=%h, want 0 %h", o_unf, o_out, m_pc);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 16'($urandom));
    checks++;
    if (o_depth !== 4'd3) begin
      errors++; $display("FAIL pre_reset_depth: depth=%0d, want 3", o_depth);
    end
    @(negedge clk);
    en = 1'b1; op = 3'd0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_out !== RV || o_depth !== 4'd0 || o_empty !== 1'b1) begin
      errors++; $display("FAIL async_reset: out=%h depth=%0d, want %h 0", o_out, o_depth, RV);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic       e;
    logic [2:0] o;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      o = 3'($urandom_range(0, 7));
      if (o > 3'd4 && $urandom_range(0, 1) == 1) o = 3'($urandom_range(3, 4));
      step(e, o, 16'($urandom));
      checks++;
      if (o_out !== m_pc || o_depth !== 4'(m_stack.size()) ||
          o_full !== (m_stack.size() == 8) || o_empty !== (m_stack.size() == 0) ||
          o_ovf !== m_ovf || o_unf !== m_unf) begin
        errors++;
        $display("FAIL random_%0d: out=%h depth=%0d ovf=%b unf=%b, want %h %0d %b %b",
                 i, o_out, o_depth, o_ovf, o_unf, m_pc, m_stack.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_branch();
    test_call_ret();
    test_overflow();
    test_underflow_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
